// File: rtl/cal_dac_pkg.sv
// Purpose : shared types and defaults for the calibration DAC sweep sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: sequencer state enum, default DAC/command/counter widths, write-update command.
package cal_dac_pkg;

  localparam int CAL_DAC_BITS   = 12;
  localparam int CAL_CMD_BITS   = 4;
  localparam int CAL_CNT_W      = 16;
  localparam int CAL_CLK_DIV    = 4;
  localparam int CAL_FRAME_BITS = CAL_CMD_BITS + CAL_DAC_BITS;

  localparam logic [CAL_CMD_BITS-1:0] CAL_CMD_WRITE_UPDATE = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_SETTLE,
    S_PULSE,
    S_GAP,
    S_NEXT,
    S_FIN
  } seq_state_t;

endpackage

// File: rtl/cal_dac_spi_tx.sv
// Purpose : 3-wire SPI (mode 0, MSB first) transmitter for one DAC frame.
// Latency : CS_n falls the cycle after start; frame holds CS_n low (2*FRAME_BITS+1)*CLK_DIV cycles.
// Backpressure: start ignored while busy; abort drops CS_n/SCLK on the next edge.
// Ports: clk/rst; start+frame load a frame; abort cancels; busy while CS_n low;
//        done is high during the final CS_n-low cycle (CS_n rises on that edge);
//        cs_n/sclk/mosi drive the DAC pins.
module cal_dac_spi_tx #(
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_TAIL} phase_t;

  logic [FRAME_BITS-1:0] shreg;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  phase_t                phase;
  logic                  tick;

  // MOSI comes straight from the shift register MSB, so it only moves when
  // the register is loaded (CS fall) or shifted (SCLK fall).
  assign mosi = shreg[FRAME_BITS-1];
  assign tick = busy && (div_cnt == DIV_LAST);
  assign done = tick && (phase == PH_TAIL) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= PH_LOW;
    end else if (abort) begin
      busy    <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      phase   <= PH_LOW;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      cs_n    <= 1'b0;
      sclk    <= 1'b0;
      shreg   <= frame;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= PH_LOW;
    end else if (busy) begin
      if (!tick) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        case (phase)
          PH_LOW: begin
            sclk  <= 1'b1;
            phase <= PH_HIGH;
          end
          PH_HIGH: begin
            sclk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              // Last bit clocked: hold SCLK low one more half-period before CS_n rises.
              phase <= PH_TAIL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg << 1;
              phase   <= PH_LOW;
            end
          end
          PH_TAIL: begin
            busy  <= 1'b0;
            cs_n  <= 1'b1;
            phase <= PH_LOW;
          end
          default: phase <= PH_LOW;
        endcase
      end
    end
  end

endmodule

// File: rtl/cal_dac_sweep_sequencer.sv
// Purpose : steps the cal DAC through a code sweep: SPI write, settle, N cal pulses per code.
// Latency : busy the edge after start; first CS_n fall one cycle later; done one cycle after last step.
// Backpressure: start ignored while busy; abort returns to idle next cycle without done.
// Ports: ACLK/ARESET; cfg_* sweep configuration (latched on start); start/abort control;
//        busy/done/cur_code/step_idx status; cal_pulse trigger; dac_cs_n/dac_sclk/dac_mosi SPI pins.
module cal_dac_sweep_sequencer
  import cal_dac_pkg::*;
#(
  parameter int DAC_BITS = CAL_DAC_BITS,
  parameter int CMD_BITS = CAL_CMD_BITS,
  parameter logic [CMD_BITS-1:0] CMD_WRITE_UPDATE = CMD_BITS'(CAL_CMD_WRITE_UPDATE),
  parameter int CLK_DIV  = CAL_CLK_DIV,
  parameter int CNT_W    = CAL_CNT_W
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [DAC_BITS-1:0] cfg_start_code,
  input  logic [DAC_BITS-1:0] cfg_step,
  input  logic [CNT_W-1:0]    cfg_num_steps,
  input  logic [CNT_W-1:0]    cfg_pulses,
  input  logic [CNT_W-1:0]    cfg_settle,
  input  logic [CNT_W-1:0]    cfg_pulse_gap,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [DAC_BITS-1:0] cur_code,
  output logic [CNT_W-1:0]    step_idx,
  output logic                cal_pulse,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi
);

  localparam int FRAME_BITS = CMD_BITS + DAC_BITS;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  seq_state_t            state;
  logic [DAC_BITS-1:0]   code;
  logic [DAC_BITS-1:0]   step_r;
  logic [CNT_W-1:0]      num_steps_r;
  logic [CNT_W-1:0]      pulses_r;
  logic [CNT_W-1:0]      settle_r;
  logic [CNT_W-1:0]      gap_r;
  logic [CNT_W-1:0]      tmr;
  logic [CNT_W-1:0]      pcnt;

  logic                  tx_start;
  logic                  tx_busy;
  logic                  tx_done;
  logic [FRAME_BITS-1:0] tx_frame;

  assign tx_start = (state == S_LOAD) && !tx_busy;
  assign tx_frame = {CMD_WRITE_UPDATE, code};

  cal_dac_spi_tx #(
    .FRAME_BITS (FRAME_BITS),
    .CLK_DIV    (CLK_DIV)
  ) u_spi_tx (
    .clk   (ACLK),
    .rst   (ARESET),
    .start (tx_start),
    .frame (tx_frame),
    .abort (abort),
    .busy  (tx_busy),
    .done  (tx_done),
    .cs_n  (dac_cs_n),
    .sclk  (dac_sclk),
    .mosi  (dac_mosi)
  );

  // Timers count edges since the reference event: tmr==k on the k-th edge
  // after CS_n rise (settle) or after the previous pulse (gap), so the
  // pulse lands exactly settle / gap cycles later.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cal_pulse   <= 1'b0;
      cur_code    <= '0;
      step_idx    <= '0;
      code        <= '0;
      step_r      <= '0;
      num_steps_r <= '0;
      pulses_r    <= '0;
      settle_r    <= '0;
      gap_r       <= ONE;
      tmr         <= '0;
      pcnt        <= '0;
    end else begin
      done      <= 1'b0;
      cal_pulse <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              code        <= cfg_start_code;
              cur_code    <= cfg_start_code;
              step_idx    <= '0;
              step_r      <= cfg_step;
              num_steps_r <= cfg_num_steps;
              pulses_r    <= cfg_pulses;
              settle_r    <= cfg_settle;
              gap_r       <= (cfg_pulse_gap == '0) ? ONE : cfg_pulse_gap;
              busy        <= 1'b1;
              state       <= (cfg_num_steps == '0) ? S_FIN : S_LOAD;
            end
          end
          S_LOAD: begin
            if (!tx_busy) begin
              cur_code <= code;
              pcnt     <= '0;
              state    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (tx_done) begin
              if (settle_r != '0) begin
                tmr   <= ONE;
                state <= S_SETTLE;
              end else if (pulses_r == '0) begin
                state <= S_NEXT;
              end else begin
                cal_pulse <= 1'b1;
                pcnt      <= ONE;
                state     <= S_PULSE;
              end
            end
          end
          S_SETTLE: begin
            if (tmr == settle_r) begin
              if (pulses_r == '0) begin
                state <= S_NEXT;
              end else begin
                cal_pulse <= 1'b1;
                pcnt      <= ONE;
                state     <= S_PULSE;
              end
            end else begin
              tmr <= tmr + ONE;
            end
          end
          S_PULSE: begin
            if (pcnt == pulses_r) begin
              state <= S_NEXT;
            end else if (gap_r == ONE) begin
              // Back-to-back pulses: stay here and fire again next cycle.
              cal_pulse <= 1'b1;
              pcnt      <= pcnt + ONE;
            end else begin
              tmr   <= TWO;
              state <= S_GAP;
            end
          end
          S_GAP: begin
            if (tmr == gap_r) begin
              cal_pulse <= 1'b1;
              pcnt      <= pcnt + ONE;
              state     <= S_PULSE;
            end else begin
              tmr <= tmr + ONE;
            end
          end
          S_NEXT: begin
            step_idx <= step_idx + ONE;
            code     <= code + step_r;
            state    <= ((step_idx + ONE) == num_steps_r) ? S_FIN : S_LOAD;
          end
          S_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cal_dac_sweep_sequencer.sv
// Purpose : directed self-checking bench for cal_dac_sweep_sequencer (CLK_DIV=2).
// Latency : n/a.
// Backpressure: n/a.
module tb_cal_dac_sweep_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [11:0] cfg_start_code = '0;
  logic [11:0] cfg_step = '0;
  logic [15:0] cfg_num_steps = '0;
  logic [15:0] cfg_pulses = '0;
  logic [15:0] cfg_settle = '0;
  logic [15:0] cfg_pulse_gap = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, cal_pulse, dac_cs_n, dac_sclk, dac_mosi;
  logic [11:0] cur_code;
  logic [15:0] step_idx;

  cal_dac_sweep_sequencer #(.CLK_DIV(2)) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .cfg_start_code (cfg_start_code),
    .cfg_step       (cfg_step),
    .cfg_num_steps  (cfg_num_steps),
    .cfg_pulses     (cfg_pulses),
    .cfg_settle     (cfg_settle),
    .cfg_pulse_gap  (cfg_pulse_gap),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .cur_code       (cur_code),
    .step_idx       (step_idx),
    .cal_pulse      (cal_pulse),
    .dac_cs_n       (dac_cs_n),
    .dac_sclk       (dac_sclk),
    .dac_mosi       (dac_mosi)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Pin-level monitor: rebuilds SPI frames and timestamps CS_n rise, pulses, done.
  logic [15:0] mon_frame [0:63];
  int          mon_rise  [0:63];
  int          mon_len   [0:63];
  int          mon_bits  [0:63];
  int          mon_pulse [0:255];
  int          nfr = 0, npl = 0, ndone = 0, fall_c = 0, cur_bits = 0;
  logic [15:0] shv = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge ACLK) begin
    if (prev_cs && !dac_cs_n) begin
      fall_c   = cyc;
      cur_bits = 0;
      shv      = '0;
    end
    if (!dac_cs_n && dac_sclk && !prev_sclk) begin
      shv      = {shv[14:0], dac_mosi};
      cur_bits = cur_bits + 1;
    end
    if (!prev_cs && dac_cs_n) begin
      if (nfr < 64) begin
        mon_frame[nfr] = shv;
        mon_rise[nfr]  = cyc;
        mon_len[nfr]   = cyc - fall_c;
        mon_bits[nfr]  = cur_bits;
      end
      nfr = nfr + 1;
    end
    if (cal_pulse === 1'b1) begin
      if (npl < 256) mon_pulse[npl] = cyc;
      npl = npl + 1;
    end
    if (done === 1'b1) ndone = ndone + 1;
    prev_cs   = dac_cs_n;
    prev_sclk = dac_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [11:0] sc, input logic [11:0] st, input int ns,
                         input int np, input int se, input int gp);
    cfg_start_code = sc;
    cfg_step       = st;
    cfg_num_steps  = 16'(ns);
    cfg_pulses     = 16'(np);
    cfg_settle     = 16'(se);
    cfg_pulse_gap  = 16'(gp);
  endtask

  task automatic do_start();
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge ACLK);
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    @(negedge ACLK);
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  // Expected sweep from first principles: frame = {3, code}, code advancing by
  // step modulo 4096; 66 CS_n-low cycles at CLK_DIV=2; first pulse settle
  // cycles after CS_n rise; following pulses max(gap,1) apart.
  task automatic check_sweep(input string tag, input int fb, input int pb, input int ns,
                             input logic [11:0] c0, input logic [11:0] st,
                             input int np, input int se, input int gp);
    logic [11:0] code;
    int          sp;
    code = c0;
    sp   = (gp == 0) ? 1 : gp;
    chk({tag, "_nframes"}, 32'(nfr - fb), 32'(ns));
    chk({tag, "_npulses"}, 32'(npl - pb), 32'(ns * np));
    if ((nfr - fb == ns) && (npl - pb == ns * np)) begin
      for (int s = 0; s < ns; s++) begin
        chk($sformatf("%s_frame%0d", tag, s), {16'd0, mon_frame[fb + s]}, {16'd0, 4'h3, code});
        chk($sformatf("%s_cslow%0d", tag, s), 32'(mon_len[fb + s]), 32'd66);
        chk($sformatf("%s_bits%0d", tag, s), 32'(mon_bits[fb + s]), 32'd16);
        if (np > 0)
          chk($sformatf("%s_settle%0d", tag, s),
              32'(mon_pulse[pb + s * np] - mon_rise[fb + s]), 32'(se));
        for (int k = 1; k < np; k++)
          chk($sformatf("%s_gap%0d_%0d", tag, s, k),
              32'(mon_pulse[pb + s * np + k] - mon_pulse[pb + s * np + k - 1]), 32'(sp));
        code = code + st;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fb, pb, db, n;

    // ---- reset values ----
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cs_n", {31'd0, dac_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, dac_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, dac_mosi}, 32'd0);
    chk("rst_pulse", {31'd0, cal_pulse}, 32'd0);
    chk("rst_code", {20'd0, cur_code}, 32'd0);
    chk("rst_idx", {16'd0, step_idx}, 32'd0);
    ARESET = 1'b0;
    repeat (3) @(posedge ACLK);

    // ---- basic sweep ----
    set_cfg(12'h100, 12'h010, 3, 2, 5, 4);
    fb = nfr; pb = npl; db = ndone;
    do_start();
    @(negedge ACLK);
    chk("s1_busy_rise", {31'd0, busy}, 32'd1);
    wait_done("s1", 2000);
    check_sweep("s1", fb, pb, 3, 12'h100, 12'h010, 2, 5, 4);
    chk("s1_ndone", 32'(ndone - db), 32'd1);
    chk("s1_cur_code", {20'd0, cur_code}, 32'h120);
    chk("s1_step_idx", {16'd0, step_idx}, 32'd3);

    // ---- zero steps: done right away, no SPI ----
    set_cfg(12'h0AB, 12'h001, 0, 2, 5, 4);
    fb = nfr; pb = npl; db = ndone;
    do_start();
    @(negedge ACLK);
    chk("s0_busy", {31'd0, busy}, 32'd1);
    chk("s0_done_early", {31'd0, done}, 32'd0);
    @(negedge ACLK);
    chk("s0_done", {31'd0, done}, 32'd1);
    chk("s0_busy_low", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge ACLK);
    chk("s0_cs_falls", 32'(nfr - fb), 32'd0);
    chk("s0_cs_n", {31'd0, dac_cs_n}, 32'd1);
    chk("s0_pulses", 32'(npl - pb), 32'd0);
    chk("s0_ndone", 32'(ndone - db), 32'd1);

    // ---- code wrap, zero settle, zero gap ----
    set_cfg(12'hFF0, 12'h020, 2, 2, 0, 0);
    fb = nfr; pb = npl;
    do_start();
    wait_done("wr", 2000);
    check_sweep("wr", fb, pb, 2, 12'hFF0, 12'h020, 2, 0, 0);
    chk("wr_cur_code", {20'd0, cur_code}, 32'h010);
    chk("wr_step_idx", {16'd0, step_idx}, 32'd2);

    // ---- zero pulses ----
    set_cfg(12'h200, 12'h001, 2, 0, 3, 4);
    fb = nfr; pb = npl; db = ndone;
    do_start();
    wait_done("np", 2000);
    check_sweep("np", fb, pb, 2, 12'h200, 12'h001, 0, 3, 4);
    chk("np_ndone", 32'(ndone - db), 32'd1);

    // ---- abort mid-frame, then full restart ----
    set_cfg(12'h100, 12'h010, 3, 2, 5, 4);
    fb = nfr; db = ndone;
    do_start();
    n = 0;
    while (!(dac_cs_n === 1'b0 && cur_bits == 8) && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    chk("ab_reach_bit7", 32'(cur_bits), 32'd8);
    @(posedge ACLK); #1 abort = 1'b1;
    @(posedge ACLK); #1 abort = 1'b0;
    chk("ab_cs_n", {31'd0, dac_cs_n}, 32'd1);
    chk("ab_sclk", {31'd0, dac_sclk}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge ACLK);
    chk("ab_no_done", 32'(ndone - db), 32'd0);
    chk("ab_one_partial", 32'(nfr - fb), 32'd1);
    chk("ab_partial_short", {31'd0, mon_bits[fb] < 16}, 32'd1);
    fb = nfr; pb = npl;
    do_start();
    wait_done("ar", 2000);
    check_sweep("ar", fb, pb, 3, 12'h100, 12'h010, 2, 5, 4);

    // ---- abort and start together in idle: no sweep ----
    fb = nfr;
    @(posedge ACLK); #1 start = 1'b1; abort = 1'b1;
    @(posedge ACLK); #1 start = 1'b0; abort = 1'b0;
    chk("as_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge ACLK);
    chk("as_no_frame", {31'd0, dac_cs_n}, 32'd1);
    chk("as_nframes", 32'(nfr - fb), 32'd0);

    // ---- start and config changes while busy are ignored ----
    set_cfg(12'h100, 12'h010, 3, 2, 5, 4);
    fb = nfr; pb = npl; db = ndone;
    do_start();
    repeat (10) @(posedge ACLK);
    #1 set_cfg(12'h555, 12'h111, 1, 5, 1, 1);
    do_start();
    wait_done("ig", 2000);
    check_sweep("ig", fb, pb, 3, 12'h100, 12'h010, 2, 5, 4);
    chk("ig_ndone", 32'(ndone - db), 32'd1);
    chk("ig_cur_code", {20'd0, cur_code}, 32'h120);

    // ---- reset in the middle of settle ----
    set_cfg(12'h100, 12'h010, 3, 2, 5, 4);
    fb = nfr; pb = npl;
    do_start();
    n = 0;
    while (nfr == fb && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    chk("rs_first_frame", 32'(nfr - fb), 32'd1);
    @(posedge ACLK); #1 ARESET = 1'b1;
    #1;
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_cs_n", {31'd0, dac_cs_n}, 32'd1);
    chk("rs_sclk", {31'd0, dac_sclk}, 32'd0);
    chk("rs_mosi", {31'd0, dac_mosi}, 32'd0);
    chk("rs_code", {20'd0, cur_code}, 32'd0);
    chk("rs_idx", {16'd0, step_idx}, 32'd0);
    chk("rs_pulse", {31'd0, cal_pulse}, 32'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    repeat (20) @(negedge ACLK);
    chk("rs_no_pulses", 32'(npl - pb), 32'd0);
    chk("rs_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
